wb_stage: RTL and testbench

WB_STAGE -- requirements
Module: wb_stage

---
 rtl/wb_stage.sv | 129 ++++++++++++
 tb/tb_wb_stage.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// Writeback stage: selects alu/pc4/imm in 1 cycle, or extracts a load in >=2 cycles; in_ready drops while a load waits for data.
// Define WB_FWD_EN to add the forwarding outputs fwd_valid/fwd_rd/fwd_data/fwd_pend.
module wb_stage #(
   parameter int XLEN = 32,
   parameter int RAW  = 5
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [1:0]      in_sel,
   input  logic [2:0]      in_funct3,
   input  logic [1:0]      in_addr_lo,
   input  logic [XLEN-1:0] in_alu,
   input  logic [XLEN-1:0] in_pc4,
   input  logic [XLEN-1:0] in_imm,
   input  logic [RAW-1:0]  in_rd,
   input  logic            in_we,
   input  logic            mem_valid,
   input  logic [XLEN-1:0] mem_rdata,
   output logic            rf_we,
   output logic [RAW-1:0]  rf_rd,
   output logic [XLEN-1:0] rf_wdata
`ifdef WB_FWD_EN
   ,
   output logic            fwd_valid,
   output logic [RAW-1:0]  fwd_rd,
   output logic [XLEN-1:0] fwd_data,
   output logic            fwd_pend
`endif
);

   typedef enum logic {IDLE, WAIT_MEM} state_t;

   state_t          state, state_nxt;
   logic            accept, is_load;
   logic [RAW-1:0]  ld_rd;
   logic            ld_we;
   logic [2:0]      ld_funct3;
   logic [1:0]      ld_addr_lo;
   logic [XLEN-1:0] sel_val, load_val;
   logic [31:0]     word;
   logic [7:0]      byte_v;
   logic [15:0]     half_v;

   assign in_ready = (state == IDLE);
   assign accept   = in_valid && in_ready;
   assign is_load  = (in_sel == 2'b00);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:     if (accept && is_load) state_nxt = WAIT_MEM;
         WAIT_MEM: if (mem_valid)         state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
   end

   always_comb begin
      sel_val = in_imm;
      case (in_sel)
         2'b01:   sel_val = in_alu;
         2'b10:   sel_val = in_pc4;
         default: sel_val = in_imm;
      endcase
   end

   // Loads only ever look at the low word; halfword offset bit 0 is ignored.
   always_comb begin
      word   = mem_rdata[31:0];
      byte_v = word[7:0];
      case (ld_addr_lo)
         2'd1:    byte_v = word[15:8];
         2'd2:    byte_v = word[23:16];
         2'd3:    byte_v = word[31:24];
         default: byte_v = word[7:0];
      endcase
      half_v   = ld_addr_lo[1] ? word[31:16] : word[15:0];
      load_val = XLEN'($signed(word));
      case (ld_funct3)
         3'b000:  load_val = XLEN'($signed(byte_v));
         3'b001:  load_val = XLEN'($signed(half_v));
         3'b100:  load_val = XLEN'(byte_v);
         3'b101:  load_val = XLEN'(half_v);
         default: load_val = XLEN'($signed(word));
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rf_we      <= 1'b0;
         rf_rd      <= '0;
         rf_wdata   <= '0;
         ld_rd      <= '0;
         ld_we      <= 1'b0;
         ld_funct3  <= '0;
         ld_addr_lo <= '0;
      end else begin
         rf_we <= 1'b0;
         if (accept && is_load) begin
            ld_rd      <= in_rd;
            ld_we      <= in_we;
            ld_funct3  <= in_funct3;
            ld_addr_lo <= in_addr_lo;
         end else if (accept) begin
            rf_we    <= in_we && (in_rd != '0);
            rf_rd    <= in_rd;
            rf_wdata <= sel_val;
         end else if (state == WAIT_MEM && mem_valid) begin
            rf_we    <= ld_we && (ld_rd != '0);
            rf_rd    <= ld_rd;
            rf_wdata <= load_val;
         end
      end
   end

`ifdef WB_FWD_EN
   assign fwd_valid = rf_we;
   assign fwd_rd    = rf_rd;
   assign fwd_data  = rf_wdata;
   assign fwd_pend  = (state == WAIT_MEM) && ld_we && (ld_rd != '0);
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed cases then random traffic against a transaction-level model.
module tb_wb_stage;
   localparam int XLEN = 32;
   localparam int RAW  = 5;

   logic            clk = 1'b0;
   logic            rst_n = 1'b1;
   logic            in_valid = 1'b0, in_ready;
   logic [1:0]      in_sel = '0;
   logic [2:0]      in_funct3 = '0;
   logic [1:0]      in_addr_lo = '0;
   logic [XLEN-1:0] in_alu = '0, in_pc4 = '0, in_imm = '0;
   logic [RAW-1:0]  in_rd = '0;
   logic            in_we = 1'b0;
   logic            mem_valid = 1'b0;
   logic [XLEN-1:0] mem_rdata = '0;
   logic            rf_we;
   logic [RAW-1:0]  rf_rd;
   logic [XLEN-1:0] rf_wdata;
`ifdef WB_FWD_EN
   logic            fwd_valid, fwd_pend;
   logic [RAW-1:0]  fwd_rd;
   logic [XLEN-1:0] fwd_data;
`endif

   wb_stage #(.XLEN(XLEN), .RAW(RAW)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_sel(in_sel), .in_funct3(in_funct3), .in_addr_lo(in_addr_lo),
      .in_alu(in_alu), .in_pc4(in_pc4), .in_imm(in_imm), .in_rd(in_rd), .in_we(in_we),
      .mem_valid(mem_valid), .mem_rdata(mem_rdata),
      .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata)
`ifdef WB_FWD_EN
      , .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data), .fwd_pend(fwd_pend)
`endif
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Reference model: one outstanding load at most, plus the last write presented.
   bit          m_busy;
   bit [4:0]    m_rd;
   bit          m_we;
   bit [2:0]    m_f3;
   bit [1:0]    m_off;
   bit          e_we;
   bit [4:0]    e_rd;
   bit [31:0]   e_wdata;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic bit [31:0] load_value(input bit [2:0] f3, input bit [1:0] off, input bit [31:0] data);
      longint d, b, h, v;
      d = longint'(data);
      b = (d >> (8 * off)) & 255;
      h = (d >> (16 * (off / 2))) & 65535;
      case (f3)
         3'd0:    v = (b >= 128) ? b - 256 : b;
         3'd1:    v = (h >= 32768) ? h - 65536 : h;
         3'd4:    v = b;
         3'd5:    v = h;
         default: v = d;
      endcase
      return v[31:0];
   endfunction

   task automatic check_outputs(input string tag);
      chk({tag, "_ready"}, in_ready, !m_busy);
      chk({tag, "_we"}, rf_we, e_we);
      chk({tag, "_rd"}, rf_rd, e_rd);
      chk({tag, "_wdata"}, rf_wdata, e_wdata);
`ifdef WB_FWD_EN
      chk({tag, "_fwd_valid"}, fwd_valid, e_we);
      chk({tag, "_fwd_rd"}, fwd_rd, e_rd);
      chk({tag, "_fwd_data"}, fwd_data, e_wdata);
      chk({tag, "_fwd_pend"}, fwd_pend, m_busy && m_we && m_rd != 0);
`endif
   endtask

   task automatic cycle(input string tag);
      @(posedge clk);
      e_we = 1'b0;
      if (!m_busy) begin
         if (in_valid && in_sel == 2'b00) begin
            m_busy = 1; m_rd = in_rd; m_we = in_we; m_f3 = in_funct3; m_off = in_addr_lo;
         end else if (in_valid) begin
            e_we    = in_we && in_rd != 0;
            e_rd    = in_rd;
            e_wdata = (in_sel == 2'b01) ? in_alu : (in_sel == 2'b10) ? in_pc4 : in_imm;
         end
      end else if (mem_valid) begin
         m_busy  = 0;
         e_we    = m_we && m_rd != 0;
         e_rd    = m_rd;
         e_wdata = load_value(m_f3, m_off, mem_rdata);
      end
      #1;
      check_outputs(tag);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      m_busy = 0; m_rd = 0; m_we = 0; m_f3 = 0; m_off = 0;
      e_we = 0; e_rd = 0; e_wdata = 0;
      check_outputs("rst_async");
      @(posedge clk);
      #1;
      check_outputs("rst_hold");
      rst_n = 1'b1;
      #1;
      chk("rst_release_ready", in_ready, 1'b1);
   endtask

   task automatic idle_inputs();
      in_valid = 1'b0;
      mem_valid = 1'b0;
   endtask

   task automatic issue(input bit [1:0] sel, input bit [2:0] f3, input bit [1:0] off,
                        input bit [4:0] rd, input bit we);
      in_valid = 1'b1; in_sel = sel; in_funct3 = f3; in_addr_lo = off; in_rd = rd; in_we = we;
   endtask

   initial begin
      do_reset();

      // ALU writeback
      issue(2'b01, 3'd0, 2'd0, 5'd3, 1'b1);
      in_alu = 32'h1234_5678;
      cycle("alu");
      chk("alu_wdata_const", rf_wdata, 32'h1234_5678);
      chk("alu_we_const", rf_we, 1'b1);
      idle_inputs();
      cycle("alu_after");
      chk("alu_after_we_const", rf_we, 1'b0);

      // LB with wait states; a non-load offered during the wait must be held off
      issue(2'b00, 3'd0, 2'd2, 5'd5, 1'b1);
      cycle("lb_acc");
      issue(2'b01, 3'd0, 2'd0, 5'd9, 1'b1);
      in_alu = 32'hDEAD_BEEF;
      repeat (3) cycle("lb_wait");
      chk("lb_wait_ready_const", in_ready, 1'b0);
      in_valid = 1'b0;
      mem_valid = 1'b1; mem_rdata = 32'h0080_0000;
      cycle("lb_done");
      chk("lb_wdata_const", rf_wdata, 32'hFFFF_FF80);
      idle_inputs();
      cycle("lb_after");

      // LHU / LH at offset 3 (bit 0 ignored)
      issue(2'b00, 3'd5, 2'd3, 5'd6, 1'b1);
      cycle("lhu_acc");
      idle_inputs();
      mem_valid = 1'b1; mem_rdata = 32'h8001_0000;
      cycle("lhu_done");
      chk("lhu_wdata_const", rf_wdata, 32'h0000_8001);
      issue(2'b00, 3'd1, 2'd3, 5'd6, 1'b1);
      mem_valid = 1'b0;
      cycle("lh_acc");
      idle_inputs();
      mem_valid = 1'b1;
      cycle("lh_done");
      chk("lh_wdata_const", rf_wdata, 32'hFFFF_8001);
      idle_inputs();

      // back-to-back pc4 then imm to rd 0
      issue(2'b10, 3'd0, 2'd0, 5'd4, 1'b1);
      in_pc4 = 32'h0000_1004; in_imm = 32'hABCD_0000;
      cycle("pc4");
      chk("pc4_we_const", rf_we, 1'b1);
      issue(2'b11, 3'd0, 2'd0, 5'd0, 1'b1);
      cycle("imm_rd0");
      chk("imm_rd0_we_const", rf_we, 1'b0);
      chk("imm_rd0_wdata_const", rf_wdata, 32'hABCD_0000);
      idle_inputs();

      // forwarding-visible load to rd 7
      issue(2'b00, 3'd2, 2'd0, 5'd7, 1'b1);
      cycle("ld7_acc");
      idle_inputs();
      cycle("ld7_wait");
      mem_valid = 1'b1; mem_rdata = 32'h7777_0007;
      cycle("ld7_done");
      idle_inputs();

      // reset during WAIT_MEM discards the load
      issue(2'b00, 3'd2, 2'd0, 5'd8, 1'b1);
      cycle("rstld_acc");
      idle_inputs();
      mem_valid = 1'b1;
      do_reset();
      cycle("rstld_after");
      chk("rstld_we_const", rf_we, 1'b0);
      idle_inputs();

      // random traffic
      for (int i = 0; i < 400; i++) begin
         in_valid   = ($urandom_range(0, 3) != 0);
         in_sel     = 2'($urandom_range(0, 3));
         in_funct3  = 3'($urandom_range(0, 7));
         in_addr_lo = 2'($urandom_range(0, 3));
         in_rd      = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         in_we      = ($urandom_range(0, 4) != 0);
         in_alu     = $urandom; in_pc4 = $urandom; in_imm = $urandom;
         mem_valid  = ($urandom_range(0, 2) == 0);
         mem_rdata  = $urandom;
         if ($urandom_range(0, 149) == 0) do_reset();
         else cycle("rand");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
